// File: rtl/l1_cache_pkg.sv
// Shared LC-3b cache types: address fields, bus widths, geometry constants,
// controller state encoding and the byte-merge helper.
package l1_cache_pkg;

  typedef logic [15:0]  lc3b_word;
  typedef logic [15:0]  lc3b_mem_wmask;
  typedef logic [127:0] lc3b_datbus;
  typedef logic [8:0]   lc3b_c_tag;
  typedef logic [2:0]   lc3b_c_index;
  typedef logic [3:0]   lc3b_c_offset;

  localparam int unsigned NUM_SETS = 32'd8;
  localparam int unsigned NUM_WAYS = 32'd2;

  typedef enum logic [1:0] {
    ST_COMPARE   = 2'd0,
    ST_WRITEBACK = 2'd1,
    ST_ALLOCATE  = 2'd2
  } cache_state_e;

  function automatic lc3b_datbus merge_line(input lc3b_datbus old_line,
                                            input lc3b_datbus wdata,
                                            input lc3b_mem_wmask be);
    lc3b_datbus result;
    result = old_line;
    for (int i = 0; i < 16; i++) begin
      if (be[i]) begin
        result[i*8 +: 8] = wdata[i*8 +: 8];
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/l1_cache_control.sv
// Cache controller FSM: hit/victim decode, miss bookkeeping and the
// registered physical-memory handshake.
module l1_cache_control
  import l1_cache_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                mem_read,
  input  logic                mem_write,
  input  lc3b_c_tag           req_tag,
  input  lc3b_c_index         req_index,
  input  logic [NUM_WAYS-1:0] way_valid,
  input  logic [NUM_WAYS-1:0] way_dirty,
  input  lc3b_c_tag           way0_tag,
  input  lc3b_c_tag           way1_tag,
  input  logic                lru_bit,
  input  logic                pmem_resp,
  output logic                mem_resp,
  output logic                hit_way,
  output logic                fill_en,
  output logic                clean_en,
  output logic                miss_way,
  output lc3b_c_index         miss_index,
  output lc3b_c_tag           miss_tag,
  output logic                pmem_read,
  output logic                pmem_write,
  output lc3b_word            pmem_address
);

  cache_state_e state_r;
  logic         pmem_read_r;
  logic         pmem_write_r;
  lc3b_word     pmem_address_r;
  logic         miss_way_r;
  lc3b_c_index  miss_index_r;
  lc3b_c_tag    miss_tag_r;

  logic         req_s;
  logic         hit0_s;
  logic         hit1_s;
  logic         hit_s;
  logic         victim_s;
  logic         victim_dirty_s;
  lc3b_c_tag    victim_tag_s;

  // Tag compare and victim choice for the set currently addressed.
  always_comb begin
    req_s          = mem_read | mem_write;
    hit0_s         = way_valid[0] && (way0_tag == req_tag);
    hit1_s         = way_valid[1] && (way1_tag == req_tag);
    hit_s          = hit0_s | hit1_s;
    hit_way        = hit1_s;
    if (!way_valid[0]) begin
      victim_s = 1'b0;
    end else if (!way_valid[1]) begin
      victim_s = 1'b1;
    end else begin
      victim_s = lru_bit;
    end
    victim_dirty_s = way_valid[victim_s] & way_dirty[victim_s];
    victim_tag_s   = victim_s ? way1_tag : way0_tag;
  end

  // Strobes that commit array updates at the end of the current cycle.
  always_comb begin
    mem_resp = (!rst) && (state_r == ST_COMPARE) && req_s && hit_s;
    fill_en  = (state_r == ST_ALLOCATE) && pmem_resp;
    clean_en = (state_r == ST_WRITEBACK) && pmem_resp;
  end

  // Miss sequencing; the victim and request are latched so a dropped or
  // changed CPU request cannot corrupt an in-flight transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= ST_COMPARE;
      pmem_read_r    <= 1'b0;
      pmem_write_r   <= 1'b0;
      pmem_address_r <= 16'h0000;
      miss_way_r     <= 1'b0;
      miss_index_r   <= 3'd0;
      miss_tag_r     <= 9'd0;
    end else begin
      case (state_r)
        ST_COMPARE: begin
          if (req_s && !hit_s) begin
            miss_way_r   <= victim_s;
            miss_index_r <= req_index;
            miss_tag_r   <= req_tag;
            if (victim_dirty_s) begin
              state_r        <= ST_WRITEBACK;
              pmem_write_r   <= 1'b1;
              pmem_address_r <= {victim_tag_s, req_index, 4'h0};
            end else begin
              state_r        <= ST_ALLOCATE;
              pmem_read_r    <= 1'b1;
              pmem_address_r <= {req_tag, req_index, 4'h0};
            end
          end
        end
        ST_WRITEBACK: begin
          if (pmem_resp) begin
            state_r        <= ST_ALLOCATE;
            pmem_write_r   <= 1'b0;
            pmem_read_r    <= 1'b1;
            pmem_address_r <= {miss_tag_r, miss_index_r, 4'h0};
          end
        end
        ST_ALLOCATE: begin
          if (pmem_resp) begin
            state_r     <= ST_COMPARE;
            pmem_read_r <= 1'b0;
          end
        end
        default: begin
          state_r      <= ST_COMPARE;
          pmem_read_r  <= 1'b0;
          pmem_write_r <= 1'b0;
        end
      endcase
    end
  end

  assign pmem_read    = pmem_read_r;
  assign pmem_write   = pmem_write_r;
  assign pmem_address = pmem_address_r;
  assign miss_way     = miss_way_r;
  assign miss_index   = miss_index_r;
  assign miss_tag     = miss_tag_r;

endmodule

// File: rtl/l1_cache.sv
// Two-way set-associative write-back L1 cache: tag/state/data arrays,
// LRU bits and write merge around the l1_cache_control FSM.
module l1_cache
  import l1_cache_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  lc3b_word      mem_address,
  input  logic          mem_read,
  input  logic          mem_write,
  input  lc3b_mem_wmask mem_byte_enable,
  input  lc3b_datbus    mem_wdata,
  output lc3b_datbus    mem_rdata,
  output logic          mem_resp,
  output lc3b_word      pmem_address,
  output logic          pmem_read,
  output logic          pmem_write,
  output lc3b_datbus    pmem_wdata,
  input  lc3b_datbus    pmem_rdata,
  input  logic          pmem_resp
);

  logic [NUM_WAYS-1:0] valid_r [NUM_SETS];
  logic [NUM_WAYS-1:0] dirty_r [NUM_SETS];
  lc3b_c_tag           tag_r   [NUM_SETS][NUM_WAYS];
  lc3b_datbus          data_r  [NUM_SETS][NUM_WAYS];
  logic [NUM_SETS-1:0] lru_r;

  lc3b_c_tag    tag_s;
  lc3b_c_index  index_s;
  lc3b_c_offset unused_offset_s;
  logic         hit_way_s;
  logic         fill_en_s;
  logic         clean_en_s;
  logic         miss_way_s;
  lc3b_c_index  miss_index_s;
  lc3b_c_tag    miss_tag_s;

  assign tag_s           = mem_address[15:7];
  assign index_s         = mem_address[6:4];
  assign unused_offset_s = mem_address[3:0];

  l1_cache_control u_control (
    .clk          (clk),
    .rst          (rst),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .req_tag      (tag_s),
    .req_index    (index_s),
    .way_valid    (valid_r[index_s]),
    .way_dirty    (dirty_r[index_s]),
    .way0_tag     (tag_r[index_s][0]),
    .way1_tag     (tag_r[index_s][1]),
    .lru_bit      (lru_r[index_s]),
    .pmem_resp    (pmem_resp),
    .mem_resp     (mem_resp),
    .hit_way      (hit_way_s),
    .fill_en      (fill_en_s),
    .clean_en     (clean_en_s),
    .miss_way     (miss_way_s),
    .miss_index   (miss_index_s),
    .miss_tag     (miss_tag_s),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address)
  );

  // Line state and replacement bits; a write hit marks the line dirty.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_r[s] <= {NUM_WAYS{1'b0}};
        dirty_r[s] <= {NUM_WAYS{1'b0}};
      end
      lru_r <= {NUM_SETS{1'b0}};
    end else begin
      if (fill_en_s) begin
        valid_r[miss_index_s][miss_way_s] <= 1'b1;
        dirty_r[miss_index_s][miss_way_s] <= 1'b0;
        tag_r[miss_index_s][miss_way_s]   <= miss_tag_s;
      end
      if (clean_en_s) begin
        dirty_r[miss_index_s][miss_way_s] <= 1'b0;
      end
      if (mem_resp) begin
        lru_r[index_s] <= ~hit_way_s;
        if (mem_write) begin
          dirty_r[index_s][hit_way_s] <= 1'b1;
        end
      end
    end
  end

  // Data lines are not reset; valid bits guard them.
  always_ff @(posedge clk) begin
    if (fill_en_s && !rst) begin
      data_r[miss_index_s][miss_way_s] <= pmem_rdata;
    end else if (mem_resp && mem_write) begin
      data_r[index_s][hit_way_s] <=
        merge_line(data_r[index_s][hit_way_s], mem_wdata, mem_byte_enable);
    end
  end

  assign mem_rdata  = data_r[index_s][hit_way_s];
  assign pmem_wdata = data_r[miss_index_s][miss_way_s];

endmodule

// File: tb/tb_l1_cache.sv
// Directed self-checking bench for l1_cache with a fixed-latency memory model.
module tb_l1_cache;

  localparam int PMEM_LAT = 3;

  logic         clk;
  logic         rst;
  logic [15:0]  mem_address;
  logic         mem_read;
  logic         mem_write;
  logic [15:0]  mem_byte_enable;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_resp;
  logic [15:0]  pmem_address;
  logic         pmem_read;
  logic         pmem_write;
  logic [127:0] pmem_wdata;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;

  int n_cmp;
  int n_bad;
  int pm_cnt;
  logic both_high;
  logic [15:0]  rd_addr_q[$];
  logic [15:0]  wr_addr_q[$];
  logic [127:0] wr_data_q[$];
  logic [127:0] mem_q[int];

  l1_cache dut (
    .clk             (clk),
    .rst             (rst),
    .mem_address     (mem_address),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_byte_enable (mem_byte_enable),
    .mem_wdata       (mem_wdata),
    .mem_rdata       (mem_rdata),
    .mem_resp        (mem_resp),
    .pmem_address    (pmem_address),
    .pmem_read       (pmem_read),
    .pmem_write      (pmem_write),
    .pmem_wdata      (pmem_wdata),
    .pmem_rdata      (pmem_rdata),
    .pmem_resp       (pmem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [127:0] pattern(input logic [15:0] a);
    return {a, ~a, a ^ 16'h5A5A, a ^ 16'hA5A5, a + 16'h0101, 16'hC0DE, a, ~a};
  endfunction

  function automatic logic [127:0] backing(input logic [15:0] a);
    if (mem_q.exists(int'(a))) return mem_q[int'(a)];
    return pattern(a);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    pmem_resp = 1'b0;
  endtask

  task automatic clear_logs();
    rd_addr_q.delete();
    wr_addr_q.delete();
    wr_data_q.delete();
    both_high = 1'b0;
  endtask

  // Memory model: answers pmem_resp PMEM_LAT cycles after the first request cycle.
  task automatic pmem_service();
    if (pmem_read && pmem_write) both_high = 1'b1;
    if (pmem_read || pmem_write) begin
      if (pm_cnt == 0) begin
        if (pmem_write) begin
          wr_addr_q.push_back(pmem_address);
          wr_data_q.push_back(pmem_wdata);
        end else begin
          rd_addr_q.push_back(pmem_address);
        end
      end
      pm_cnt++;
      if (pm_cnt == PMEM_LAT + 1) begin
        if (pmem_write) mem_q[int'(pmem_address)] = pmem_wdata;
        else pmem_rdata = backing(pmem_address);
        pmem_resp = 1'b1;
        pm_cnt = 0;
      end
    end else begin
      pm_cnt = 0;
    end
  endtask

  task automatic do_req(input logic [15:0] addr, input logic rd, input logic wr,
                        input logic [15:0] be, input logic [127:0] wd,
                        output int lat, output logic [127:0] rdata);
    mem_address = addr;
    mem_read = rd;
    mem_write = wr;
    mem_byte_enable = be;
    mem_wdata = wd;
    lat = -1;
    rdata = 128'd0;
    for (int c = 0; c < 60; c++) begin
      #1;
      if (mem_resp) begin
        lat = c;
        rdata = mem_rdata;
      end
      pmem_service();
      tick();
      if (lat >= 0) break;
    end
    mem_read = 1'b0;
    mem_write = 1'b0;
    if (lat < 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL req_timeout: addr %h got no mem_resp within 60 cycles", addr);
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    mem_read = 1'b0;
    mem_write = 1'b0;
    pmem_resp = 1'b0;
    pm_cnt = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    n_cmp++; if (mem_resp !== 1'b0) begin n_bad++; $display("FAIL reset_mem_resp: got %b want 0", mem_resp); end
    n_cmp++; if (pmem_read !== 1'b0) begin n_bad++; $display("FAIL reset_pmem_read: got %b want 0", pmem_read); end
    n_cmp++; if (pmem_write !== 1'b0) begin n_bad++; $display("FAIL reset_pmem_write: got %b want 0", pmem_write); end
    tick();
  endtask

  task automatic test_cold_read();
    int lat;
    logic [127:0] rd;
    logic [15:0] ra;
    clear_logs();
    do_req(16'h1230, 1'b1, 1'b0, 16'h0000, 128'd0, lat, rd);
    ra = (rd_addr_q.size() > 0) ? rd_addr_q[0] : 16'hxxxx;
    n_cmp++; if (lat !== 5) begin n_bad++; $display("FAIL cold_latency: got %0d want 5", lat); end
    n_cmp++; if (ra !== 16'h1230) begin n_bad++; $display("FAIL cold_pmem_addr: got %h want 1230", ra); end
    n_cmp++; if (rd !== pattern(16'h1230)) begin n_bad++; $display("FAIL cold_rdata: got %h want %h", rd, pattern(16'h1230)); end
    n_cmp++; if (wr_addr_q.size() !== 0) begin n_bad++; $display("FAIL cold_no_wb: got %0d writebacks want 0", wr_addr_q.size()); end
    do_req(16'h1238, 1'b1, 1'b0, 16'h0000, 128'd0, lat, rd);
    n_cmp++; if (lat !== 0) begin n_bad++; $display("FAIL rehit_latency: got %0d want 0", lat); end
    n_cmp++; if (rd !== pattern(16'h1230)) begin n_bad++; $display("FAIL rehit_rdata: got %h want %h", rd, pattern(16'h1230)); end
  endtask

  task automatic test_write_hit();
    int lat;
    logic [127:0] rd, p, exp;
    logic [15:0] wa, ra;
    p = pattern(16'h1230);
    exp = {p[127:16], 16'hBEEF};
    do_req(16'h1230, 1'b0, 1'b1, 16'h0003, {8{16'hBEEF}}, lat, rd);
    n_cmp++; if (lat !== 0) begin n_bad++; $display("FAIL wrhit_latency: got %0d want 0", lat); end
    do_req(16'h1230, 1'b1, 1'b0, 16'h0000, 128'd0, lat, rd);
    n_cmp++; if (rd !== exp) begin n_bad++; $display("FAIL wrhit_merge: got %h want %h", rd, exp); end
    // Fill the other way, then force eviction of the dirty line.
    do_req(16'h1330, 1'b1, 1'b0, 16'h0000, 128'd0, lat, rd);
    n_cmp++; if (lat !== 5) begin n_bad++; $display("FAIL way1_fill_latency: got %0d want 5", lat); end
    clear_logs();
    do_req(16'h1430, 1'b1, 1'b0, 16'h0000, 128'd0, lat, rd);
    wa = (wr_addr_q.size() > 0) ? wr_addr_q[0] : 16'hxxxx;
    ra = (rd_addr_q.size() > 0) ? rd_addr_q[0] : 16'hxxxx;
    n_cmp++; if (lat !== 9) begin n_bad++; $display("FAIL dirty1_latency: got %0d want 9", lat); end
    n_cmp++; if (wa !== 16'h1230) begin n_bad++; $display("FAIL dirty1_wb_addr: got %h want 1230", wa); end
    n_cmp++; if (wr_data_q.size() == 0 || wr_data_q[0] !== exp) begin n_bad++; $display("FAIL dirty1_wb_data: got %0d entries want line %h", wr_data_q.size(), exp); end
    n_cmp++; if (ra !== 16'h1430) begin n_bad++; $display("FAIL dirty1_fill_addr: got %h want 1430", ra); end
  endtask

  task automatic test_lru();
    int lat;
    logic [127:0] rd;
    logic [15:0] ra;
    apply_reset();
    do_req(16'h0030, 1'b1, 1'b0, 16'h0000, 128'd0, lat, rd);
    do_req(16'h0430, 1'b1, 1'b0, 16'h0000, 128'd0, lat, rd);
    n_cmp++; if (lat !== 5) begin n_bad++; $display("FAIL lru_fill1_latency: got %0d want 5", lat); end
    do_req(16'h0030, 1'b1, 1'b0, 16'h0000, 128'd0, lat, rd);
    n_cmp++; if (lat !== 0) begin n_bad++; $display("FAIL lru_touch_latency: got %0d want 0", lat); end
    clear_logs();
    do_req(16'h0830, 1'b1, 1'b0, 16'h0000, 128'd0, lat, rd);
    ra = (rd_addr_q.size() > 0) ? rd_addr_q[0] : 16'hxxxx;
    n_cmp++; if (lat !== 5) begin n_bad++; $display("FAIL lru_evict_latency: got %0d want 5", lat); end
    n_cmp++; if (ra !== 16'h0830) begin n_bad++; $display("FAIL lru_fill_addr: got %h want 0830", ra); end
    do_req(16'h0030, 1'b1, 1'b0, 16'h0000, 128'd0, lat, rd);
    n_cmp++; if (lat !== 0) begin n_bad++; $display("FAIL lru_survivor: got %0d want 0", lat); end
    n_cmp++; if (rd !== pattern(16'h0030)) begin n_bad++; $display("FAIL lru_survivor_data: got %h want %h", rd, pattern(16'h0030)); end
    do_req(16'h0430, 1'b1, 1'b0, 16'h0000, 128'd0, lat, rd);
    n_cmp++; if (lat !== 5) begin n_bad++; $display("FAIL lru_victim_gone: got %0d want 5", lat); end
  endtask

  task automatic test_dirty_evict();
    int lat;
    logic [127:0] rd, p, exp;
    logic [15:0] wa, ra;
    p = pattern(16'h0430);
    exp = {{4{16'h1122}}, p[63:0]};
    do_req(16'h0430, 1'b0, 1'b1, 16'hFF00, {8{16'h1122}}, lat, rd);
    do_req(16'h0030, 1'b1, 1'b0, 16'h0000, 128'd0, lat, rd);
    clear_logs();
    do_req(16'h0C30, 1'b1, 1'b0, 16'h0000, 128'd0, lat, rd);
    wa = (wr_addr_q.size() > 0) ? wr_addr_q[0] : 16'hxxxx;
    ra = (rd_addr_q.size() > 0) ? rd_addr_q[0] : 16'hxxxx;
    n_cmp++; if (lat !== 9) begin n_bad++; $display("FAIL dirty2_latency: got %0d want 9", lat); end
    n_cmp++; if (wa !== 16'h0430) begin n_bad++; $display("FAIL dirty2_wb_addr: got %h want 0430", wa); end
    n_cmp++; if (wr_data_q.size() == 0 || wr_data_q[0] !== exp) begin n_bad++; $display("FAIL dirty2_wb_data: got %0d entries want line %h", wr_data_q.size(), exp); end
    n_cmp++; if (ra !== 16'h0C30) begin n_bad++; $display("FAIL dirty2_fill_addr: got %h want 0c30", ra); end
    n_cmp++; if (both_high !== 1'b0) begin n_bad++; $display("FAIL pmem_exclusive: got both-high %b want 0", both_high); end
    n_cmp++; if (rd !== pattern(16'h0C30)) begin n_bad++; $display("FAIL dirty2_rdata: got %h want %h", rd, pattern(16'h0C30)); end
  endtask

  task automatic test_reset_midfill();
    int lat;
    logic [127:0] rd;
    logic [15:0] ra;
    mem_address = 16'h1630;
    mem_read = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      pmem_service();
      tick();
    end
    n_cmp++; if (pmem_read !== 1'b1) begin n_bad++; $display("FAIL midfill_pending: got pmem_read %b want 1", pmem_read); end
    rst = 1'b1;
    mem_read = 1'b0;
    tick();
    rst = 1'b0;
    pm_cnt = 0;
    n_cmp++; if (pmem_read !== 1'b0) begin n_bad++; $display("FAIL midfill_abort: got pmem_read %b want 0", pmem_read); end
    clear_logs();
    do_req(16'h0030, 1'b1, 1'b0, 16'h0000, 128'd0, lat, rd);
    ra = (rd_addr_q.size() > 0) ? rd_addr_q[0] : 16'hxxxx;
    n_cmp++; if (lat !== 5) begin n_bad++; $display("FAIL midfill_invalidate: got latency %0d want 5", lat); end
    n_cmp++; if (ra !== 16'h0030) begin n_bad++; $display("FAIL midfill_refill_addr: got %h want 0030", ra); end
  endtask

  task automatic test_drop_request();
    int lat;
    int resp_cnt;
    logic [127:0] rd;
    logic [15:0] ra;
    clear_logs();
    resp_cnt = 0;
    mem_address = 16'h1730;
    mem_read = 1'b1;
    #1;
    if (mem_resp) resp_cnt++;
    pmem_service();
    tick();
    mem_read = 1'b0;
    mem_address = 16'h0000;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (mem_resp) resp_cnt++;
      pmem_service();
      tick();
    end
    ra = (rd_addr_q.size() > 0) ? rd_addr_q[0] : 16'hxxxx;
    n_cmp++; if (resp_cnt !== 0) begin n_bad++; $display("FAIL drop_no_resp: got %0d responses want 0", resp_cnt); end
    n_cmp++; if (ra !== 16'h1730) begin n_bad++; $display("FAIL drop_fill_addr: got %h want 1730", ra); end
    n_cmp++; if (pmem_read !== 1'b0) begin n_bad++; $display("FAIL drop_fill_done: got pmem_read %b want 0", pmem_read); end
    do_req(16'h1730, 1'b1, 1'b0, 16'h0000, 128'd0, lat, rd);
    n_cmp++; if (lat !== 0) begin n_bad++; $display("FAIL drop_then_hit: got latency %0d want 0", lat); end
    n_cmp++; if (rd !== pattern(16'h1730)) begin n_bad++; $display("FAIL drop_data: got %h want %h", rd, pattern(16'h1730)); end
  endtask

  task automatic test_back_to_back();
    int lat0, lat1, lat2;
    logic [127:0] rd, p, exp;
    p = pattern(16'h0030);
    exp = {p[127:32], 32'h77887788};
    // Read and write both high must act as a write.
    do_req(16'h0030, 1'b1, 1'b1, 16'h000F, {8{16'h7788}}, lat0, rd);
    do_req(16'h1730, 1'b1, 1'b0, 16'h0000, 128'd0, lat1, rd);
    do_req(16'h0034, 1'b1, 1'b0, 16'h0000, 128'd0, lat2, rd);
    n_cmp++; if (lat0 !== 0) begin n_bad++; $display("FAIL b2b_first: got %0d want 0", lat0); end
    n_cmp++; if (lat1 !== 0) begin n_bad++; $display("FAIL b2b_second: got %0d want 0", lat1); end
    n_cmp++; if (lat2 !== 0) begin n_bad++; $display("FAIL b2b_third: got %0d want 0", lat2); end
    n_cmp++; if (rd !== exp) begin n_bad++; $display("FAIL rw_as_write: got %h want %h", rd, exp); end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    pm_cnt = 0;
    both_high = 1'b0;
    rst = 1'b1;
    mem_address = 16'h0000;
    mem_read = 1'b0;
    mem_write = 1'b0;
    mem_byte_enable = 16'h0000;
    mem_wdata = 128'd0;
    pmem_rdata = 128'd0;
    pmem_resp = 1'b0;
    test_reset();
    test_cold_read();
    test_write_hit();
    test_lru();
    test_dirty_evict();
    test_reset_midfill();
    test_drop_request();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
